// File: rtl/count_tick_gen.sv
// Single-clock tick generator feeding the LED counter's EN/RDY method handshake.
// Divides CLK by (div_value+1), holds an undelivered tick pending and counts ticks lost while pending.
module count_tick_gen #(
  parameter int DIV_WIDTH = 23,
  parameter int OVR_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 rdy_in,
  output logic                 en_out,
  output logic                 tick_pending,
  output logic                 heartbeat,
  output logic [OVR_WIDTH-1:0] overrun_count
);

  logic [DIV_WIDTH-1:0] prescaler_reg, prescaler_next;
  logic                 pending_reg, pending_next;
  logic                 heartbeat_reg, heartbeat_next;
  logic [OVR_WIDTH-1:0] overrun_reg, overrun_next;
  logic                 tick;
  logic                 fire;

  always_comb begin
    // >= rather than == so a lowered div_value ends the current period immediately
    tick           = run & (prescaler_reg >= div_value);
    fire           = pending_reg & rdy_in;
    prescaler_next = prescaler_reg;
    pending_next   = tick | (pending_reg & ~fire);
    heartbeat_next = heartbeat_reg ^ fire;
    overrun_next   = overrun_reg;

    if (tick) begin
      prescaler_next = '0;
    end else if (run) begin
      prescaler_next = prescaler_reg + DIV_WIDTH'(1);
    end

    // A tick arriving while the previous one is still undelivered is lost
    if (tick & pending_reg & ~fire & ~(&overrun_reg)) begin
      overrun_next = overrun_reg + OVR_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler_reg <= '0;
      pending_reg   <= 1'b0;
      heartbeat_reg <= 1'b0;
      overrun_reg   <= '0;
    end else begin
      prescaler_reg <= prescaler_next;
      pending_reg   <= pending_next;
      heartbeat_reg <= heartbeat_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign en_out        = fire;
  assign tick_pending  = pending_reg;
  assign heartbeat     = heartbeat_reg;
  assign overrun_count = overrun_reg;

endmodule
